// File: rtl/gcd_driver.sv
// Buffers operand pairs in a 4-deep FIFO and runs them one at a time through an external GCD core, with timeout.
// Pop to gcd_go is 1 cycle, gcd_done to res_valid is 1 cycle; in_ready is !full, and the result is held until res_ready.
module gcd_driver #(
  parameter int width   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_x,
  input  logic [width-1:0] in_y,
  output logic [width-1:0] gcd_x,
  output logic [width-1:0] gcd_y,
  output logic             gcd_go,
  input  logic             gcd_done,
  input  logic [width-1:0] gcd_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2*width-1:0] mem_q [4];
  logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               fifo_full, fifo_empty, push, pop;
  logic [width-1:0]   head_x, head_y;

  state_t             state_q;
  logic [7:0]         wait_q;
  logic               gcd_go_q, res_valid_q, res_err_q;
  logic [width-1:0]   gcd_x_q, gcd_y_q, res_data_q;

  assign fifo_full        = (cnt_q == 3'd4);
  assign fifo_empty       = (cnt_q == 3'd0);
  assign push             = in_valid && !fifo_full;
  assign pop              = (state_q == S_IDLE) && !fifo_empty;
  assign {head_x, head_y} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (pop && !push) cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= 8'd0;
      gcd_go_q    <= 1'b0;
      gcd_x_q     <= '0;
      gcd_y_q     <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (head_x == '0 || head_y == '0) begin
              res_data_q  <= head_x | head_y;
              res_err_q   <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              gcd_x_q  <= head_x;
              gcd_y_q  <= head_y;
              gcd_go_q <= 1'b1;
              wait_q   <= 8'd0;
              state_q  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // A completion on the final wait cycle takes priority over the timeout.
          if (gcd_done) begin
            res_data_q  <= gcd_result;
            res_err_q   <= 1'b0;
            gcd_go_q    <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (wait_q == WAIT_LAST) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            gcd_go_q    <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = !fifo_full;
  assign gcd_go    = gcd_go_q;
  assign gcd_x     = gcd_x_q;
  assign gcd_y     = gcd_y_q;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gcd_driver.sv
// Directed bench for gcd_driver (TIMEOUT=8) with a behavioural GCD core of programmable latency.
module tb_gcd_driver;
  localparam int W = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic [W-1:0] gcd_x, gcd_y;
  logic         gcd_go;
  logic         gcd_done = 1'b0;
  logic [W-1:0] gcd_result = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  int lat = 5;
  bit core_en = 1'b1;
  bit done_force = 1'b0;
  int go_cyc = 0;

  gcd_driver #(.width(W), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .gcd_x(gcd_x), .gcd_y(gcd_y), .gcd_go(gcd_go),
    .gcd_done(gcd_done), .gcd_result(gcd_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p, q, t;
    p = a;
    q = b;
    while (q != '0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Core model: gcd_done pulses in the lat-th cycle that gcd_go is seen high.
  always @(negedge clock) begin
    if (gcd_go) begin
      go_cyc   = go_cyc + 1;
      gcd_done = done_force || (core_en && go_cyc == lat);
    end else begin
      go_cyc   = 0;
      gcd_done = done_force;
    end
    gcd_result = gcd_f(gcd_x, gcd_y);
  end

  task automatic push_one(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int max_cyc, input bit ack, output int idx, output int gon,
                          output logic [W-1:0] d, output logic e);
    idx = -1;
    gon = 0;
    d = 'x;
    e = 1'bx;
    for (int i = 0; i < max_cyc; i++) begin
      if (res_valid) begin
        idx = i;
        d = res_data;
        e = res_err;
        break;
      end
      if (gcd_go) gon++;
      @(negedge clock);
    end
    if (idx >= 0 && ack) begin
      res_ready = 1'b1;
      @(negedge clock);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    n_cmp++; if (gcd_go !== 1'b0)    begin n_err++; $display("FAIL reset_go: got %b want 0", gcd_go); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    n_cmp++; if (res_err !== 1'b0)   begin n_err++; $display("FAIL reset_err: got %b want 0", res_err); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({gcd_x, gcd_y, res_data} !== '0) begin n_err++; $display("FAIL reset_data: got %h/%h/%h want 0", gcd_x, gcd_y, res_data); end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int go_first, rv_idx, go_n;
    logic [W-1:0] gx, gy;
    lat = 5;
    go_first = -1; rv_idx = -1; go_n = 0; gx = '0; gy = '0;
    push_one(5'd12, 5'd18);
    for (int i = 0; i < 40 && rv_idx < 0; i++) begin
      if (gcd_go) begin
        go_n++;
        if (go_first < 0) begin go_first = i; gx = gcd_x; gy = gcd_y; end
      end
      if (res_valid) rv_idx = i;
      else @(negedge clock);
    end
    n_cmp++; if (go_first !== 1) begin n_err++; $display("FAIL basic_go_latency: got %0d want 1", go_first); end
    n_cmp++; if (go_n !== 5)     begin n_err++; $display("FAIL basic_go_cycles: got %0d want 5", go_n); end
    n_cmp++; if (rv_idx !== 6)   begin n_err++; $display("FAIL basic_valid_latency: got %0d want 6", rv_idx); end
    n_cmp++; if ({gx, gy} !== {5'd12, 5'd18}) begin n_err++; $display("FAIL basic_operands: got %0d,%0d want 12,18", gx, gy); end
    n_cmp++; if (res_data !== 5'd6) begin n_err++; $display("FAIL basic_data: got %0d want 6", res_data); end
    n_cmp++; if (res_err !== 1'b0)  begin n_err++; $display("FAIL basic_err: got %b want 0", res_err); end
    @(negedge clock);
    n_cmp++; if ({res_valid, res_data, busy} !== {1'b1, 5'd6, 1'b1}) begin n_err++; $display("FAIL basic_hold: got v=%b d=%0d b=%b want 1,6,1", res_valid, res_data, busy); end
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    n_cmp++; if ({res_valid, busy} !== 2'b00) begin n_err++; $display("FAIL basic_release: got v=%b b=%b want 0,0", res_valid, busy); end
  endtask

  task automatic test_zero_operand();
    int idx, gon;
    logic [W-1:0] d;
    logic e;
    push_one(5'd0, 5'd7);
    wait_res(20, 1'b1, idx, gon, d, e);
    n_cmp++; if ({idx, gon} !== {32'sd1, 32'sd0}) begin n_err++; $display("FAIL zero_a_timing: got idx=%0d go=%0d want 1,0", idx, gon); end
    n_cmp++; if ({d, e} !== {5'd7, 1'b0}) begin n_err++; $display("FAIL zero_a_result: got %0d err=%b want 7,0", d, e); end
    push_one(5'd9, 5'd0);
    wait_res(20, 1'b1, idx, gon, d, e);
    n_cmp++; if ({idx, gon} !== {32'sd1, 32'sd0}) begin n_err++; $display("FAIL zero_b_timing: got idx=%0d go=%0d want 1,0", idx, gon); end
    n_cmp++; if ({d, e} !== {5'd9, 1'b0}) begin n_err++; $display("FAIL zero_b_result: got %0d err=%b want 9,0", d, e); end
  endtask

  task automatic test_timeout();
    int idx, gon;
    logic [W-1:0] d;
    logic e;
    core_en = 1'b0;
    push_one(5'd4, 5'd6);
    wait_res(40, 1'b1, idx, gon, d, e);
    n_cmp++; if (gon !== 8) begin n_err++; $display("FAIL timeout_go_cycles: got %0d want 8", gon); end
    n_cmp++; if ({d, e} !== {5'd0, 1'b1}) begin n_err++; $display("FAIL timeout_result: got %0d err=%b want 0,1", d, e); end
    core_en = 1'b1;
    lat = 3;
    push_one(5'd4, 5'd6);
    wait_res(40, 1'b1, idx, gon, d, e);
    n_cmp++; if ({d, e} !== {5'd2, 1'b0}) begin n_err++; $display("FAIL timeout_recover: got %0d err=%b want 2,0", d, e); end
    n_cmp++; if (gon !== 3) begin n_err++; $display("FAIL timeout_recover_go: got %0d want 3", gon); end
  endtask

  task automatic test_fifo_full();
    logic [W-1:0] xs [6] = '{5'd12, 5'd0, 5'd4, 5'd9, 5'd15, 5'd3};
    logic [W-1:0] ys [6] = '{5'd18, 5'd7, 5'd6, 5'd0, 5'd25, 5'd3};
    logic [W-1:0] exp_d [5] = '{5'd6, 5'd7, 5'd2, 5'd9, 5'd5};
    logic [5:0] rdy;
    int idx, gon;
    logic [W-1:0] d;
    logic e;
    lat = 2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      rdy[i] = in_ready;
      in_valid = 1'b1;
      in_x = xs[i];
      in_y = ys[i];
    end
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++; if (rdy !== 6'b011111) begin n_err++; $display("FAIL full_accept: got %b want 011111", rdy); end
    repeat (3) @(negedge clock);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    for (int k = 0; k < 5; k++) begin
      wait_res(30, 1'b1, idx, gon, d, e);
      n_cmp++; if ({d, e} !== {exp_d[k], 1'b0}) begin n_err++; $display("FAIL full_order_%0d: got %0d err=%b want %0d,0", k, d, e, exp_d[k]); end
    end
    repeat (4) @(negedge clock);
    n_cmp++; if ({busy, res_valid} !== 2'b00) begin n_err++; $display("FAIL full_drained: got b=%b v=%b want 0,0", busy, res_valid); end
  endtask

  task automatic test_back_to_back();
    int n, v0, v1;
    logic [W-1:0] d0, d1;
    n = 0; v0 = -1; v1 = -1; d0 = '0; d1 = '0;
    lat = 3;
    res_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b1; in_x = 5'd12; in_y = 5'd18;
    @(negedge clock);
    in_x = 5'd4; in_y = 5'd6;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) begin
        if (n == 0) begin v0 = i; d0 = res_data; end
        if (n == 1) begin v1 = i; d1 = res_data; end
        n++;
      end
      @(negedge clock);
    end
    res_ready = 1'b0;
    n_cmp++; if (n !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", n); end
    n_cmp++; if (v1 - v0 !== 5) begin n_err++; $display("FAIL b2b_spacing: got %0d want 5", v1 - v0); end
    n_cmp++; if ({d0, d1} !== {5'd6, 5'd2}) begin n_err++; $display("FAIL b2b_data: got %0d,%0d want 6,2", d0, d1); end
  endtask

  task automatic test_reset_mid();
    bit seen_v, seen_go;
    lat = 20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_x = 5'd12;
      in_y = 5'd18;
    end
    @(negedge clock);
    in_valid = 1'b0;
    n_cmp++; if ({gcd_go, busy} !== 2'b11) begin n_err++; $display("FAIL rstmid_pre: got go=%b b=%b want 1,1", gcd_go, busy); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if ({gcd_go, res_valid, busy} !== 3'b000) begin n_err++; $display("FAIL rstmid_async: got go=%b v=%b b=%b want 0,0,0", gcd_go, res_valid, busy); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    lat = 5;
    n_cmp++; if ({busy, in_ready} !== 2'b01) begin n_err++; $display("FAIL rstmid_after: got b=%b rdy=%b want 0,1", busy, in_ready); end
    seen_v = 1'b0; seen_go = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      seen_v  = seen_v | res_valid;
      seen_go = seen_go | gcd_go;
    end
    n_cmp++; if ({seen_v, seen_go} !== 2'b00) begin n_err++; $display("FAIL rstmid_stale: got v=%b go=%b want 0,0", seen_v, seen_go); end
  endtask

  task automatic test_done_corners();
    bit seen_v, seen_go;
    int idx, gon;
    logic [W-1:0] d;
    logic e;
    done_force = 1'b1;
    repeat (2) @(negedge clock);
    done_force = 1'b0;
    seen_v = 1'b0; seen_go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      seen_v  = seen_v | res_valid;
      seen_go = seen_go | gcd_go;
    end
    n_cmp++; if ({seen_v, seen_go, busy} !== 3'b000) begin n_err++; $display("FAIL idle_done: got v=%b go=%b b=%b want 0,0,0", seen_v, seen_go, busy); end
    lat = 8;
    push_one(5'd4, 5'd6);
    wait_res(40, 1'b1, idx, gon, d, e);
    n_cmp++; if (gon !== 8) begin n_err++; $display("FAIL coincide_go_cycles: got %0d want 8", gon); end
    n_cmp++; if ({d, e} !== {5'd2, 1'b0}) begin n_err++; $display("FAIL coincide_result: got %0d err=%b want 2,0", d, e); end
    lat = 5;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_operand();
    test_timeout();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    test_done_corners();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_driver.md
GCD_DRIVER -- requirements
Module: gcd_driver

Interface
REQ-001 The block SHALL have parameter width, default 5, giving the operand and result bit width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for gcd_done per transaction (legal range 2..255).
REQ-003 The block SHALL have these ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- in_x, in_y  in  width  operand pair.
- gcd_x, gcd_y  out  width  operands to the GCD core.
- gcd_go  out  1  start/hold request to the GCD core.
- gcd_done  in  1  one-cycle completion pulse from the GCD core.
- gcd_result  in  width  core result, valid in the gcd_done cycle.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result when res_valid and res_ready are both high.
- res_data  out  width  GCD result.
- res_err  out  1  high when the transaction timed out.
- busy  out  1  high when not in S_IDLE or the FIFO is non-empty.

Function
REQ-004 Requests SHALL pass through a 4-entry FIFO; in_ready SHALL be !full, and a request presented while full SHALL be left unaccepted, never dropped or overwritten.
REQ-005 A push and a pop in the same cycle SHALL both take effect and leave the occupancy unchanged; the FIFO pointers SHALL wrap modulo 4.
REQ-006 The FSM SHALL have three states, S_IDLE, S_BUSY and S_RESP, and SHALL be encoded in 2 bits.
REQ-007 In S_IDLE with the FIFO non-empty, the block SHALL pop one entry in that cycle.
- If either operand is zero: load res_data = in_x | in_y and res_err = 0, go to S_RESP, and do not assert gcd_go.
- Otherwise: register gcd_x and gcd_y, set gcd_go = 1, clear the wait counter, and go to S_BUSY.
REQ-008 In S_BUSY, gcd_go SHALL remain 1 and gcd_x and gcd_y SHALL remain stable until the exit cycle.
REQ-009 In S_BUSY, if gcd_done = 1, the block SHALL capture gcd_result into res_data, set res_err = 0, drive gcd_go to 0 on the next edge, and go to S_RESP.
REQ-010 In S_BUSY, if gcd_done = 0 and the wait counter equals TIMEOUT-1, the block SHALL set res_data = 0 and res_err = 1, drive gcd_go to 0, and go to S_RESP; otherwise the counter SHALL increment by 1.
REQ-011 If gcd_done coincides with the timeout cycle, gcd_done SHALL win and no error SHALL be flagged.
REQ-012 gcd_done asserted outside S_BUSY SHALL be ignored.
REQ-013 In S_RESP, res_valid SHALL be 1 and res_data and res_err SHALL be held stable; on res_ready = 1 the block SHALL return to S_IDLE.
REQ-014 res_valid SHALL be a registered output that is high only in S_RESP.
REQ-015 Back-to-back throughput SHALL be one transaction per (core latency + 2) cycles when res_ready is held high; the block SHALL never overlap two core transactions.
REQ-016 From FIFO pop to gcd_go rising SHALL be exactly 1 cycle; from gcd_done to res_valid rising SHALL be exactly 1 cycle; a zero-operand request SHALL reach res_valid 1 cycle after pop.
REQ-017 FIFO pushes SHALL continue normally while the FSM is in S_BUSY or S_RESP.

Reset
REQ-018 Asserting reset SHALL, asynchronously, set the FSM to S_IDLE and empty the FIFO.
REQ-019 Asserting reset SHALL, asynchronously, set gcd_go, res_valid, res_err and busy to 0 and set gcd_x, gcd_y, res_data and the wait counter to 0.
REQ-020 in_ready SHALL be 1 after reset deasserts.
REQ-021 Reset asserted mid-transaction SHALL drop gcd_go in the same cycle, and any in-flight or buffered request SHALL be discarded without producing a result.

Verification
REQ-022 Push (12,18); core model returns 6 with gcd_done 5 cycles after gcd_go -> gcd_go high for 5 cycles, then res_valid=1, res_data=6, res_err=0.
REQ-023 Push (0,7) and then (9,0) -> gcd_go never asserts; results are 7 then 9 with res_err=0, each 1 cycle after pop.
REQ-024 TIMEOUT=8, gcd_done held 0 on (4,6) -> gcd_go falls after 8 cycles in S_BUSY; res_data=0, res_err=1; a following request (4,6) with a working core returns 2.
REQ-025 Hold res_ready=0 and push 6 requests back-to-back -> 5 are accepted (1 in flight plus 4 buffered) and in_ready=0 on the 6th; release res_ready -> all 5 results come out in order.
REQ-026 Assert reset 2 cycles into S_BUSY with 2 entries buffered -> gcd_go=0 and res_valid=0 immediately; after release busy=0, in_ready=1, and no stale result appears.
REQ-027 gcd_done pulsed while the block is in S_IDLE, and gcd_done coinciding with the timeout cycle -> the first is ignored; the second gives res_err=0 and res_data=gcd_result.
